ntt_out_reorder: RTL

Ping-pong reorder buffer directly downstream of the pipelined forward NTT. It captures the NTT's continuous two-lane output stream (`out_en` / `out[2]`), which arrives in bit-reversed coefficient order, and re-emits each polynomial in natural order as coefficient pairs. The output side uses a valid/ready handshake, which decouples the non-stallable NTT pipeline from a back-pressuring consumer such as pointwise multiply or a store unit.

---
 rtl/ntt_out_reorder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ntt_out_reorder.sv
// Ping-pong reorder buffer behind the forward NTT.
// Captures bit-reversed coefficient pairs from the NTT and re-emits each
// polynomial in natural order over a valid/ready output port.
//
// Output handshake: a pair transfers on any rising edge where
// out_valid & out_ready are both high; while out_valid is high and
// out_ready is low, out, out_last and out_valid hold their values.
// The input side has no backpressure: every in_en cycle is consumed,
// and a polynomial that finds no free bank is dropped (overflow).
module ntt_out_reorder #(
    parameter int WIDTH = 12,
    parameter int LOG_N = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_en,
    input  logic [WIDTH-1:0] in [2],
    output logic             in_ready,
    output logic [WIDTH-1:0] out [2],
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             overflow
);

    localparam int N  = 1 << LOG_N;
    localparam int CW = LOG_N - 1;
    localparam logic [CW-1:0] LAST = {CW{1'b1}};

    // Coefficient index bit reversal over LOG_N bits.
    function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
        logic [LOG_N-1:0] r;
        for (int i = 0; i < LOG_N; i++) begin
            r[i] = x[LOG_N-1-i];
        end
        return r;
    endfunction

    // Two banks of N coefficients, flip-flop based (2 writes + 2 reads per cycle).
    logic [WIDTH-1:0] mem [2][N];

    logic [1:0]    full;
    logic [1:0]    full_next;
    logic          wr_bank;
    logic          rd_bank;
    logic          drop;
    logic [CW-1:0] wr_cnt;
    logic [CW-1:0] rd_cnt;

    logic             wr_start;
    logic             rd_load;
    logic             rd_release;
    logic             bank_free;
    logic             wr_drop;
    logic             wr_do;
    logic             wr_done;
    logic [LOG_N-1:0] wr_idx0;
    logic [LOG_N-1:0] wr_idx1;
    logic [LOG_N-1:0] rd_idx0;
    logic [LOG_N-1:0] rd_idx1;

    // Write/read control decode; a bank released by the reader this cycle
    // counts as free for a polynomial starting in the same cycle.
    always_comb begin
        wr_start   = in_en && (wr_cnt == '0);
        rd_load    = full[rd_bank] && (!out_valid || out_ready);
        rd_release = rd_load && (rd_cnt == LAST);
        bank_free  = !full[wr_bank] || (rd_release && (rd_bank == wr_bank));
        wr_drop    = wr_start ? !bank_free : drop;
        wr_do      = in_en && !wr_drop;
        wr_done    = wr_do && (wr_cnt == LAST);
        wr_idx0    = bitrev({wr_cnt, 1'b0});
        wr_idx1    = bitrev({wr_cnt, 1'b1});
        rd_idx0    = {rd_cnt, 1'b0};
        rd_idx1    = {rd_cnt, 1'b1};
        full_next  = full;
        if (rd_release) begin
            full_next[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    assign in_ready = !full[wr_bank];

    // Bank storage: scatter the incoming pair to its natural-order slots.
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_bank][wr_idx0] <= in[0];
            mem[wr_bank][wr_idx1] <= in[1];
        end
    end

    // Bank flags, counters, drop/overflow tracking and the output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            drop      <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out[0]    <= '0;
            out[1]    <= '0;
        end else begin
            full <= full_next;
            if (in_en) begin
                wr_cnt <= wr_cnt + 1'b1;
                drop   <= (wr_cnt == LAST) ? 1'b0 : wr_drop;
                if (wr_start && !bank_free) begin
                    overflow <= 1'b1;
                end
            end
            if (wr_done) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_load) begin
                out[0]    <= mem[rd_bank][rd_idx0];
                out[1]    <= mem[rd_bank][rd_idx1];
                out_valid <= 1'b1;
                out_last  <= (rd_cnt == LAST);
                rd_cnt    <= rd_cnt + 1'b1;
                if (rd_release) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule
